// File: rtl/uart_tx.sv
// UART transmitter that pops bytes from a TX FIFO and serialises them LSB first.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx #(
    parameter int DBITS        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DBITS > STOP_BITS) ? $clog2(DBITS) : $clog2(STOP_BITS + 1);

    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DBITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DBITS-1:0]  shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bit_end = (timer_q == TIMER_MAX);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = REQ;
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_data;
                timer_d = '0;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            STOP: begin
                // idx_q counts stop bits here so two stop bits reuse the same bit timer
                if (bit_end) begin
                    timer_d = '0;
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered tx lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign fifo_rd_en   = (state_q == REQ);
    assign tx_done_tick = done_q;

endmodule
